// File: rtl/button_gesture_decoder.sv
// Turns debounced button level/edge pulses into single-cycle gesture strobes:
// short press, long press, double press and auto-repeat while a long press is held.
module button_gesture_decoder #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned LONG_CYCLES   = 50000,
    parameter int unsigned GAP_CYCLES    = 20000,
    parameter int unsigned REPEAT_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_state,
    input  logic btn_down,
    input  logic btn_up,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_tick,
    output logic busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS1   = 3'd1,
        ST_GAP      = 3'd2,
        ST_HELD     = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    // Terminal counts: the strobe lands one cycle after cnt reaches value-1.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             released;

    // A dropped level counts as a release even if the btn_up pulse was missed.
    assign released = btn_up | ~btn_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            repeat_tick  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            repeat_tick  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (btn_down) begin
                        state <= ST_PRESS1;
                        busy  <= 1'b1;
                    end
                end
                ST_PRESS1: begin
                    if (released) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= ST_HELD;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (btn_down) begin
                        state        <= ST_WAIT_REL;
                        cnt          <= '0;
                        double_press <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        state       <= ST_IDLE;
                        cnt         <= '0;
                        short_press <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (released) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt         <= '0;
                        repeat_tick <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    cnt <= '0;
                    if (released) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder: scenario table, async reset sequence and a
// randomized press timeline checked against an interval-arithmetic model.
module tb_button_gesture_decoder;

    localparam int CNT_W  = 8;
    localparam int LONG   = 8;
    localparam int GAP    = 5;
    localparam int REP    = 4;
    localparam int WIN    = 50;
    localparam int NCYC   = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_state = 1'b0;
    logic btn_down = 1'b0;
    logic btn_up = 1'b0;
    logic short_press, long_press, double_press, repeat_tick, busy;

    int total = 0;
    int bad = 0;

    // Vector layout everywhere: {busy, short, long, double, repeat}.
    logic [4:0] exp_q[$];
    logic       in_s[NCYC];
    logic       in_d[NCYC];
    logic       in_u[NCYC];
    logic [4:0] exp_vec[NCYC];

    typedef struct {
        string name;
        int    d1;
        int    u1;
        bit    up_pulse;
        int    d2;
        int    u2;
        int    short_at;
        int    long_at;
        int    dbl_at;
        int    rep_first;
        int    rep_last;
        int    busy_lo;
        int    busy_hi;
    } scen_t;

    scen_t scens[8];

    button_gesture_decoder #(
        .CNT_W(CNT_W), .LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_state(btn_state), .btn_down(btn_down),
        .btn_up(btn_up), .short_press(short_press), .long_press(long_press),
        .double_press(double_press), .repeat_tick(repeat_tick), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic d, input logic u);
        btn_state = s;
        btn_down  = d;
        btn_up    = u;
    endtask

    function automatic logic [4:0] dut_vec();
        return {busy, short_press, long_press, double_press, repeat_tick};
    endfunction

    task automatic check(input string name, input int cyc, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b (busy,short,long,dbl,rep)", name, cyc, act, exp);
        end
    endtask

    task automatic run_scen(input scen_t s);
        logic [4:0] e;
        logic       st, dn, up;
        for (int c = 0; c < WIN; c++) begin
            step();
            e[4] = (c >= s.busy_lo) && (c <= s.busy_hi);
            e[3] = (c == s.short_at);
            e[2] = (c == s.long_at);
            e[1] = (c == s.dbl_at);
            e[0] = (s.rep_first >= 0) && (c >= s.rep_first) && (c <= s.rep_last)
                   && (((c - s.rep_first) % REP) == 0);
            check(s.name, c, dut_vec(), e);
            st = ((c >= s.d1) && (c < s.u1)) || ((s.d2 >= 0) && (c >= s.d2) && (c < s.u2));
            dn = (c == s.d1) || (c == s.d2);
            up = (s.up_pulse && (c == s.u1)) || ((s.d2 >= 0) && (c == s.u2));
            drive(st, dn, up);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Builds a random press timeline and derives expected strobes from the
    // gesture timing rules directly (press length, release gap, repeat period).
    task automatic build_random();
        int pd[$];
        int pu[$];
        bit pp[$];
        int t, len, gap, i, d, u, fin;
        for (int c = 0; c < NCYC; c++) begin
            in_s[c] = 1'b0; in_d[c] = 1'b0; in_u[c] = 1'b0; exp_vec[c] = '0;
        end
        t = 2;
        while (1) begin
            len = $urandom_range(1, 20);
            if (t + len >= NCYC - 40) break;
            pd.push_back(t);
            pu.push_back(t + len);
            pp.push_back($urandom_range(0, 3) != 0);
            gap = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 12) : $urandom_range(1, 6);
            t = t + len + gap;
        end
        for (int k = 0; k < pd.size(); k++) begin
            for (int c = pd[k]; c < pu[k]; c++) in_s[c] = 1'b1;
            in_d[pd[k]] = 1'b1;
            if (pp[k]) in_u[pu[k]] = 1'b1;
        end
        i = 0;
        while (i < pd.size()) begin
            d = pd[i];
            u = pu[i];
            if (u - d > LONG) begin
                exp_vec[d + LONG + 1][2] = 1'b1;
                for (int tk = d + LONG + 1 + REP; tk <= u; tk += REP) exp_vec[tk][0] = 1'b1;
                fin = u + 1;
                i++;
            end else if ((i + 1 < pd.size()) && (pd[i+1] <= u + GAP)) begin
                exp_vec[pd[i+1] + 1][1] = 1'b1;
                fin = pu[i+1] + 1;
                i += 2;
            end else begin
                exp_vec[u + GAP + 1][3] = 1'b1;
                fin = u + GAP + 1;
                i++;
            end
            for (int c = d + 1; c < fin; c++) exp_vec[c][4] = 1'b1;
        end
        exp_q.delete();
        for (int c = 0; c < NCYC; c++) exp_q.push_back(exp_vec[c]);
    endtask

    task automatic run_random();
        logic [4:0] e;
        for (int c = 0; c < NCYC; c++) begin
            step();
            e = exp_q.pop_front();
            check("random", c, dut_vec(), e);
            drive(in_s[c], in_d[c], in_u[c]);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        scens[0] = '{"single",      10, 13, 1'b1, -1, -1, 19, -1, -1, -1, -1, 11, 18};
        scens[1] = '{"long_repeat", 10, 40, 1'b1, -1, -1, -1, 19, -1, 23, 39, 11, 40};
        scens[2] = '{"double",      10, 12, 1'b1, 15, 30, -1, -1, 16, -1, -1, 11, 30};
        scens[3] = '{"tie_long",    10, 18, 1'b1, -1, -1, 24, -1, -1, -1, -1, 11, 23};
        scens[4] = '{"tie_gap",     10, 13, 1'b1, 18, 22, -1, -1, 19, -1, -1, 11, 22};
        scens[5] = '{"just_short",  10, 17, 1'b1, -1, -1, 23, -1, -1, -1, -1, 11, 22};
        scens[6] = '{"just_long",   10, 19, 1'b1, -1, -1, -1, 19, -1, -1, -1, 11, 19};
        scens[7] = '{"missed_up",   10, 13, 1'b0, -1, -1, 19, -1, -1, -1, -1, 11, 18};

        #12;
        check("reset_state", 0, dut_vec(), 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("idle_after_reset", c, dut_vec(), 5'b0);
        end

        for (int k = 0; k < 8; k++) run_scen(scens[k]);

        // Asynchronous reset while HELD, on a repeat tick.
        for (int c = 0; c < 24; c++) begin
            step();
            if (c == 23) check("held_before_reset", c, dut_vec(), 5'b10001);
            drive(c >= 10, c == 10, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check("async_reset", 23, dut_vec(), 5'b0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            step();
            check("up_after_reset", c, dut_vec(), 5'b0);
            drive(1'b0, 1'b0, 1'b0);
        end
        run_scen(scens[0]);

        build_random();
        run_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
